// File: rtl/wptr_handler_pkg.sv
// ---------------------------------------------------------------------------
// wptr_handler_pkg
// Shared FIFO pointer helpers used by both the write-side and read-side
// pointer handlers.
//
// Contents:
//   PTR_MAX   widest pointer the helpers handle; narrower pointers are
//             zero-extended in and size-cast back out by the caller
//   bin2gray  binary -> reflected Gray code
//   gray2bin  reflected Gray code -> binary (XOR prefix from the MSB down)
// ---------------------------------------------------------------------------
package wptr_handler_pkg;

  localparam int PTR_MAX = 16;

  // A Gray value is the binary value XORed with itself shifted right by one.
  // Zero-extension leaves the low bits unchanged, so one width serves every
  // pointer size up to PTR_MAX.
  function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it. Zero
  // upper bits contribute nothing, so any width up to PTR_MAX works.
  function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] gray);
    logic [PTR_MAX-1:0] bin;
    bin = '0;
    for (int i = 0; i < PTR_MAX; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/wptr_handler_gray2bin.sv
// ---------------------------------------------------------------------------
// gray2bin
// Combinational Gray-to-binary converter. The write-side pointer handler
// uses it to turn the synchronized read pointer back into a binary count.
//
// Ports:
//   i_gray  in   WIDTH  Gray-coded pointer
//   o_bin   out  WIDTH  equivalent binary pointer
// ---------------------------------------------------------------------------
module gray2bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  // Prefix XOR from the MSB down. Shifting right by i and reducing gives the
  // XOR of bits i..WIDTH-1 with no variable part-select.
  always_comb begin
    o_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_bin[i] = ^(i_gray >> i);
    end
  end

endmodule

// File: rtl/wptr_handler.sv
// ---------------------------------------------------------------------------
// wptr_handler
// Write-domain pointer handler for an asynchronous FIFO. It keeps the binary
// write pointer and publishes its Gray form to the read domain. It also
// derives the full, almost-full and occupancy flags from the synchronized
// read pointer, and records any write attempted while full.
//
// Ports:
//   clk          in   1            write-domain clock
//   rst          in   1            synchronous active-high reset
//   w_en         in   1            producer write request
//   rptr_sync    in   PTR_WIDTH+1  Gray read pointer, already synchronized
//   w_ack        out  1            write accepted this cycle (memory write enable)
//   waddr        out  PTR_WIDTH    memory write address
//   wptr         out  PTR_WIDTH+1  registered Gray write pointer
//   full         out  1            registered full flag
//   almost_full  out  1            registered, wlevel >= AFULL_THRESH
//   wlevel       out  PTR_WIDTH+1  registered occupancy estimate
//   overflow     out  1            sticky: write requested while full
// ---------------------------------------------------------------------------
module wptr_handler
  import wptr_handler_pkg::*;
#(
  parameter int PTR_WIDTH    = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 w_en,
  input  logic [PTR_WIDTH:0]   rptr_sync,
  output logic                 w_ack,
  output logic [PTR_WIDTH-1:0] waddr,
  output logic [PTR_WIDTH:0]   wptr,
  output logic                 full,
  output logic                 almost_full,
  output logic [PTR_WIDTH:0]   wlevel,
  output logic                 overflow
);

  localparam logic [PTR_WIDTH:0] AFULL_LVL = AFULL_THRESH[PTR_WIDTH:0];

  logic [PTR_WIDTH:0] r_wbin;
  logic [PTR_WIDTH:0] r_wgray;
  logic               r_full;
  logic               r_almostFull;
  logic [PTR_WIDTH:0] r_wlevel;
  logic               r_overflow;

  logic [PTR_WIDTH:0] w_rbin;
  logic [PTR_WIDTH:0] w_wbinNext;
  logic [PTR_WIDTH:0] w_wgrayNext;
  logic [PTR_WIDTH:0] w_fullGray;
  logic [PTR_WIDTH:0] w_levelNext;

  // Binary copy of the synchronized read pointer, used for the level math.
  gray2bin #(
    .WIDTH(PTR_WIDTH + 1)
  ) u_rptrConv (
    .i_gray(rptr_sync),
    .o_bin (w_rbin)
  );

  // w_ack uses the registered full flag, so a write that arrives in the
  // same cycle the reader frees a slot waits one cycle.
  assign w_ack = w_en & ~r_full;

  // Next-pointer math. The modulo 2^(PTR_WIDTH+1) wrap comes free from the
  // vector width. The Gray conversion goes through the shared package
  // helper at its fixed width and is cast back down.
  assign w_wbinNext  = r_wbin + {{PTR_WIDTH{1'b0}}, w_ack};
  assign w_wgrayNext = (PTR_WIDTH + 1)'(bin2gray(PTR_MAX'(w_wbinNext)));
  assign w_levelNext = w_wbinNext - w_rbin;

  // The write pointer has lapped the read pointer exactly once when its Gray
  // code equals the read pointer's Gray code with the top two bits inverted.
  assign w_fullGray = {~rptr_sync[PTR_WIDTH:PTR_WIDTH-1], rptr_sync[PTR_WIDTH-2:0]};

  // All write-domain state. The binary and Gray pointers load together each
  // edge, so wptr changes at most one bit per cycle as the read-domain
  // synchronizer requires. Overflow is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wbin       <= '0;
      r_wgray      <= '0;
      r_full       <= 1'b0;
      r_almostFull <= 1'b0;
      r_wlevel     <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_wbin       <= w_wbinNext;
      r_wgray      <= w_wgrayNext;
      r_full       <= (w_wgrayNext == w_fullGray);
      r_almostFull <= (w_levelNext >= AFULL_LVL);
      r_wlevel     <= w_levelNext;
      if (w_en && r_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign waddr       = r_wbin[PTR_WIDTH-1:0];
  assign wptr        = r_wgray;
  assign full        = r_full;
  assign almost_full = r_almostFull;
  assign wlevel      = r_wlevel;
  assign overflow    = r_overflow;

endmodule
